// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the 2-port SRAM BIST engine.
// Element order: M0 up w0, M1 up r0w1, M2 up r1w0, M3 down r0w1, M4 down r1w0, M5 up r0.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ELEM_W = 3;

  localparam logic [ELEM_W-1:0] M0 = 3'd0;
  localparam logic [ELEM_W-1:0] M1 = 3'd1;
  localparam logic [ELEM_W-1:0] M2 = 3'd2;
  localparam logic [ELEM_W-1:0] M3 = 3'd3;
  localparam logic [ELEM_W-1:0] M4 = 3'd4;
  localparam logic [ELEM_W-1:0] M5 = 3'd5;

  // Per-element tables, bit index = element code; codes 6 and 7 are unused.
  localparam logic [7:0] ELEM_DESCEND = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OP  = 8'b0001_1110;
  localparam logic [7:0] ELEM_HAS_RD  = 8'b0011_1110;
  localparam logic [7:0] ELEM_RD_ONES = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_ONES = 8'b0000_1010;

  function automatic logic elem_descend(input logic [ELEM_W-1:0] e);
    return ELEM_DESCEND[e];
  endfunction

  function automatic logic elem_rd_ones(input logic [ELEM_W-1:0] e);
    return ELEM_RD_ONES[e];
  endfunction

  function automatic logic elem_wr_ones(input logic [ELEM_W-1:0] e);
    return ELEM_WR_ONES[e];
  endfunction

  // Two-op elements always read first, then write.
  function automatic logic op_is_read(input logic [ELEM_W-1:0] e, input logic op);
    return ELEM_HAS_RD[e] & ~op;
  endfunction

  function automatic logic op_is_last(input logic [ELEM_W-1:0] e, input logic op);
    return ELEM_TWO_OP[e] ? op : 1'b1;
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Two-stage read-tracking pipeline, mismatch detection and first-fail capture.
// Capture registers exist only when SRAM_BIST_FAIL_LOG_EN is defined.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_launch_valid,
  input  logic                    i_launch_exp,
  input  logic [P_ADDR_WIDTH-1:0] i_launch_addr,
  input  logic [ELEM_W-1:0]       i_launch_elem,
  input  logic [P_DATA_WIDTH-1:0] i_dout,
  output logic                    o_fail,
  output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
  output logic [ELEM_W-1:0]       o_fail_elem,
  output logic [P_DATA_WIDTH-1:0] o_fail_bits
);

  logic                    r_a_valid;
  logic                    r_a_exp;
  logic                    r_b_valid;
  logic                    r_b_exp;
  logic                    r_fail;
  logic [P_DATA_WIDTH-1:0] w_diff;
  logic                    w_mismatch;

  // Stage A mirrors the command register, stage B lines up with DOUT.
  assign w_diff     = i_dout ^ {P_DATA_WIDTH{r_b_exp}};
  assign w_mismatch = r_b_valid && (w_diff != '0);
  assign o_fail     = r_fail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_valid <= 1'b0;
      r_a_exp   <= 1'b0;
      r_b_valid <= 1'b0;
      r_b_exp   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_a_valid <= i_launch_valid;
      r_a_exp   <= i_launch_exp;
      r_b_valid <= r_a_valid;
      r_b_exp   <= r_a_exp;
      if (i_clear) begin
        r_fail <= 1'b0;
      end else if (w_mismatch) begin
        r_fail <= 1'b1;
      end
    end
  end

`ifdef SRAM_BIST_FAIL_LOG_EN
  logic [P_ADDR_WIDTH-1:0] r_a_addr;
  logic [P_ADDR_WIDTH-1:0] r_b_addr;
  logic [ELEM_W-1:0]       r_a_elem;
  logic [ELEM_W-1:0]       r_b_elem;
  logic [P_ADDR_WIDTH-1:0] r_fail_addr;
  logic [ELEM_W-1:0]       r_fail_elem;
  logic [P_DATA_WIDTH-1:0] r_fail_bits;

  // A held capture is equivalent to r_fail already being set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_a_elem    <= '0;
      r_b_elem    <= '0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_bits <= '0;
    end else begin
      r_a_addr <= i_launch_addr;
      r_a_elem <= i_launch_elem;
      r_b_addr <= r_a_addr;
      r_b_elem <= r_a_elem;
      if (i_clear) begin
        r_fail_addr <= '0;
        r_fail_elem <= '0;
        r_fail_bits <= '0;
      end else if (w_mismatch && !r_fail) begin
        r_fail_addr <= r_b_addr;
        r_fail_elem <= r_b_elem;
        r_fail_bits <= w_diff;
      end
    end
  end

  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;
  assign o_fail_bits = r_fail_bits;
`else
  logic w_unused_launch;
  assign w_unused_launch = ^{i_launch_addr, i_launch_elem};

  assign o_fail_addr = '0;
  assign o_fail_elem = '0;
  assign o_fail_bits = '0;
`endif

endmodule

// File: rtl/sram_2p_march_bist.sv
// March C- BIST sequencer for one port of a 2-port SRAM macro (10*N command cycles).
// Define SRAM_BIST_FAIL_LOG_EN to keep first-fail address/element/bit capture.
module sram_2p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    BIST_CLK,
  input  logic                    BIST_RST_N,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [P_DATA_WIDTH-1:0] FAIL_BITS,
  output logic                    BIST_EN,
  output logic                    BIST_MEN,
  output logic                    BIST_WEN,
  output logic                    BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] DOUT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ELEM_W-1:0]       r_elem;
  logic                    r_op;
  logic [P_ADDR_WIDTH-1:0] r_addr;
  logic                    r_men;
  logic                    r_wen;
  logic                    r_ren;
  logic [P_DATA_WIDTH-1:0] r_din;
  logic [P_DATA_WIDTH-1:0] r_bm;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_op_last;
  logic                    w_addr_end;
  logic                    w_run_last;
  logic [ELEM_W-1:0]       w_elem_inc;
  logic [ELEM_W-1:0]       w_adv_elem;
  logic                    w_adv_op;
  logic [P_ADDR_WIDTH-1:0] w_adv_addr;

  logic                    w_ld;
  logic                    w_ld_rd;
  logic [ELEM_W-1:0]       w_ld_elem;
  logic                    w_ld_op;
  logic [P_ADDR_WIDTH-1:0] w_ld_addr;
  logic                    w_clear;
  logic                    w_busy_next;
  logic                    w_done_next;
  logic                    w_men_next;
  logic                    w_wen_next;
  logic                    w_ren_next;
  logic [P_DATA_WIDTH-1:0] w_din_next;

  // Position of the command following the one currently on the pins.
  assign w_op_last  = op_is_last(r_elem, r_op);
  assign w_addr_end = elem_descend(r_elem) ? (r_addr == '0) : (r_addr == ADDR_MAX);
  assign w_run_last = (r_elem == M5) && w_addr_end && w_op_last;
  assign w_elem_inc = r_elem + 3'd1;

  always_comb begin
    w_adv_elem = r_elem;
    w_adv_op   = r_op;
    w_adv_addr = r_addr;
    if (!w_op_last) begin
      w_adv_op = 1'b1;
    end else begin
      w_adv_op = 1'b0;
      if (w_addr_end) begin
        w_adv_elem = w_elem_inc;
        w_adv_addr = elem_descend(w_elem_inc) ? ADDR_MAX : '0;
      end else begin
        w_adv_addr = elem_descend(r_elem) ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld         = 1'b0;
    w_ld_elem    = w_adv_elem;
    w_ld_op      = w_adv_op;
    w_ld_addr    = w_adv_addr;
    w_clear      = 1'b0;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    unique case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_next = ST_RUN;
          w_ld         = 1'b1;
          w_ld_elem    = M0;
          w_ld_op      = 1'b0;
          w_ld_addr    = '0;
          w_clear      = 1'b1;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_run_last) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_ld = 1'b1;
        end
      end
      // The compare pipeline is fixed-latency, so one drain cycle covers the last read.
      ST_DRAIN: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
    w_ld_rd    = op_is_read(w_ld_elem, w_ld_op);
    w_men_next = w_ld;
    w_ren_next = w_ld & w_ld_rd;
    w_wen_next = w_ld & ~w_ld_rd;
    w_din_next = (w_wen_next && elem_wr_ones(w_ld_elem)) ? '1 : '0;
  end

  always_ff @(posedge BIST_CLK or negedge BIST_RST_N) begin
    if (!BIST_RST_N) begin
      r_state <= ST_IDLE;
      r_elem  <= M0;
      r_op    <= 1'b0;
      r_addr  <= '0;
      r_men   <= 1'b0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_din   <= '0;
      r_bm    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_men   <= w_men_next;
      r_wen   <= w_wen_next;
      r_ren   <= w_ren_next;
      r_din   <= w_din_next;
      r_bm    <= {P_DATA_WIDTH{w_busy_next}};
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_ld) begin
        r_elem <= w_ld_elem;
        r_op   <= w_ld_op;
        r_addr <= w_ld_addr;
      end
    end
  end

  sram_bist_cmp #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_cmp (
    .i_clk         (BIST_CLK),
    .i_rst_n       (BIST_RST_N),
    .i_clear       (w_clear),
    .i_launch_valid(w_ren_next),
    .i_launch_exp  (elem_rd_ones(w_ld_elem)),
    .i_launch_addr (w_ld_addr),
    .i_launch_elem (w_ld_elem),
    .i_dout        (DOUT),
    .o_fail        (FAIL),
    .o_fail_addr   (FAIL_ADDR),
    .o_fail_elem   (FAIL_ELEM),
    .o_fail_bits   (FAIL_BITS)
  );

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign BIST_EN   = r_busy;
  assign BIST_MEN  = r_men;
  assign BIST_WEN  = r_wen;
  assign BIST_REN  = r_ren;
  assign BIST_ADDR = r_addr;
  assign BIST_DIN  = r_din;
  assign BIST_BM   = r_bm;

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Directed bench for sram_2p_march_bist with a behavioural 2-port macro model
// and an optional stuck-at-1 read fault (bit 3 at address 0x05).
module tb_sram_2p_march_bist;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int N    = 256;
  localparam int NCMD = 10 * N;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_bits;
  logic          en, men, wen, ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, bm;
  logic [DW-1:0] dout = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_2p_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .BIST_CLK  (clk),
    .BIST_RST_N(rst_n),
    .START     (start),
    .BUSY      (busy),
    .DONE      (done),
    .FAIL      (fail),
    .FAIL_ADDR (fail_addr),
    .FAIL_ELEM (fail_elem),
    .FAIL_BITS (fail_bits),
    .BIST_EN   (en),
    .BIST_MEN  (men),
    .BIST_WEN  (wen),
    .BIST_REN  (ren),
    .BIST_ADDR (addr),
    .BIST_DIN  (din),
    .BIST_BM   (bm),
    .DOUT      (dout)
  );

  // Macro model: samples the command on the edge, DOUT registered one cycle later.
  logic [DW-1:0] mem [N];
  logic          fault_on   = 1'b0;
  logic [AW-1:0] fault_addr = 8'h05;
  logic [DW-1:0] fault_mask = 16'h0008;

  always @(posedge clk) begin
    if (en && men && wen) mem[addr] <= din;
    if (en && men && ren) dout <= mem[addr] | ((fault_on && addr == fault_addr) ? fault_mask : '0);
  end

  // Command monitor, restarts its log whenever BUSY rises.
  int            cyc       = 0;
  int            ncmd      = 0;
  int            first_cmd = -1;
  int            last_cmd  = -1;
  int            busy_cnt  = 0;
  logic          busy_q    = 1'b0;
  logic [AW-1:0] log_addr [NCMD];
  logic          log_wen  [NCMD];
  logic          log_ren  [NCMD];
  logic [DW-1:0] log_din  [NCMD];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy && !busy_q) begin
      ncmd      = 0;
      busy_cnt  = 0;
      first_cmd = -1;
      last_cmd  = -1;
    end
    busy_q = busy;
    if (busy) busy_cnt++;
    if (men) begin
      if (ncmd == 0) first_cmd = cyc;
      last_cmd = cyc;
      if (ncmd < NCMD) begin
        log_addr[ncmd] = addr;
        log_wen[ncmd]  = wen;
        log_ren[ncmd]  = ren;
        log_din[ncmd]  = din;
      end
      ncmd++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic hold, output int t);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    int i;
    i = 0;
    while (!done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    d = cyc;
  endtask

  int t, d, t2, m0_err, i;
  logic [AW-1:0] exp_faddr;
  logic [2:0]    exp_felem;
  logic [DW-1:0] exp_fbits;

  initial begin
`ifdef SRAM_BIST_FAIL_LOG_EN
    exp_faddr = 8'h05;
    exp_felem = 3'd1;
    exp_fbits = 16'h0008;
`else
    exp_faddr = 8'h00;
    exp_felem = 3'd0;
    exp_fbits = 16'h0000;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", {busy, done, fail, fail_addr, fail_elem, fail_bits}, 32'h0);
    check("rst_cmd", {en, men, wen, ren, addr}, 32'h0);
    check("rst_din_bm", {din, bm}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {busy, men}, 32'h0);

    // Fault-free run
    start_run(1'b0, t);
    check("run1_first_cmd", {busy, en, men, wen, ren, addr, din}, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000});
    check("run1_bm", bm, 32'h0000ffff);
    wait_done(d);
    check("run1_done", done, 1);
    check("run1_latency", d - t, 2561);
    check("run1_end_state", {busy, en, men, wen, ren, fail}, 32'h0);
    check("run1_bm_off", bm, 32'h0);
    check("run1_ncmd", ncmd, NCMD);
    check("run1_first_edge", first_cmd - t, 0);
    check("run1_contiguous", last_cmd - first_cmd, NCMD - 1);
    check("run1_busy_cycles", busy_cnt, 2561);
    check("run1_capture", {fail_addr, fail_elem, fail_bits}, 32'h0);
    m0_err = 0;
    for (int k = 0; k < N; k++)
      if (log_addr[k] != AW'(k) || !log_wen[k] || log_ren[k] || log_din[k] != 16'h0000) m0_err++;
    check("m0_ascend_w0", m0_err, 0);
    check("m1_start_r0", {log_addr[256], log_ren[256], log_wen[256], log_din[256]}, {8'h00, 1'b1, 1'b0, 16'h0000});
    check("m1_w1", {log_addr[257], log_ren[257], log_wen[257], log_din[257]}, {8'h00, 1'b0, 1'b1, 16'hffff});
    check("m2_start_r1", {log_addr[768], log_ren[768], log_wen[768]}, {8'h00, 1'b1, 1'b0});
    check("m2_w0", {log_addr[769], log_wen[769], log_din[769]}, {8'h00, 1'b1, 16'h0000});
    check("m3_start_r0", {log_addr[1280], log_ren[1280], log_wen[1280]}, {8'hff, 1'b1, 1'b0});
    check("m3_w1", {log_addr[1281], log_wen[1281], log_din[1281]}, {8'hff, 1'b1, 16'hffff});
    check("m3_descend", {log_addr[1282], log_ren[1282]}, {8'hfe, 1'b1});
    check("m4_start_r1", {log_addr[1792], log_ren[1792]}, {8'hff, 1'b1});
    check("m5_start_r0", {log_addr[2304], log_ren[2304], log_wen[2304]}, {8'h00, 1'b1, 1'b0});
    check("m5_last", {log_addr[2559], log_ren[2559]}, {8'hff, 1'b1});

    // Stuck-at-1 fault with START held high through the run
    fault_on = 1'b1;
    start_run(1'b1, t);
    check("run2_done_cleared", {busy, done, fail}, {1'b1, 1'b0, 1'b0});
    wait_done(d);
    check("run2_done", done, 1);
    check("run2_latency", d - t, 2561);
    check("run2_ncmd", ncmd, NCMD);
    check("run2_fail_flag", fail, 1);
    check("run2_fail_addr", fail_addr, exp_faddr);
    check("run2_fail_elem", fail_elem, exp_felem);
    check("run2_fail_bits", fail_bits, exp_fbits);

    // START still high: a new run begins on the next edge
    @(negedge clk);
    t2 = cyc;
    check("rerun_edge", t2 - d, 1);
    check("rerun_cleared", {busy, done, fail}, {1'b1, 1'b0, 1'b0});
    start = 1'b0;

    // Reset during M2
    i = 0;
    while (ncmd < 800 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("midrun_in_m2", (ncmd >= 768 && ncmd < 1280), 1);
    check("midrun_fail_seen", fail, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_status", {busy, done, fail, fail_addr, fail_elem, fail_bits}, 32'h0);
    check("async_rst_cmd", {en, men, wen, ren, addr}, 32'h0);
    check("async_rst_din_bm", {din, bm}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fault_on = 1'b0;

    // Full clean run after reset
    start_run(1'b0, t);
    check("run3_start", {busy, men, wen, addr}, {1'b1, 1'b1, 1'b1, 8'h00});
    wait_done(d);
    check("run3_latency", d - t, 2561);
    check("run3_ncmd", ncmd, NCMD);
    check("run3_clean", {done, fail, busy}, {1'b1, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
